// File: rtl/game_step_seq.sv
// Per-tick game step sequencer: paces link send, remote reception, move and collision
// stages, and tracks steps, points and the shrinking tick period.
module game_step_seq #(
  parameter int unsigned N_PLAYERS         = 2,
  parameter int unsigned TICK_CYCLES       = 7_500_000,
  parameter int unsigned MIN_TICK_CYCLES   = 1_875_000,
  parameter int unsigned SPEEDUP_STEP      = 375_000,
  parameter int unsigned SPEEDUP_EVERY     = 4,
  parameter int unsigned RX_TIMEOUT_CYCLES = 750_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [N_PLAYERS-1:0] rcv_valid,
  input  logic                 move_done,
  input  logic                 coll_done,
  input  logic [N_PLAYERS-1:0] eaten,
  input  logic                 game_over,
  output logic                 send,
  output logic                 move_start,
  output logic                 coll_start,
  output logic                 step_done,
  output logic                 com_err,
  output logic [31:0]          tick_period,
  output logic [15:0]          step_cnt,
  output logic [15:0]          points
);

  typedef enum logic [3:0] {
    StIdle, StWaitTick, StSend, StWaitRx, StMove, StCollide, StUpdate, StHalt, StError
  } state_e;

  // Local player never reports over the link, so its mask bit is always considered present.
  localparam logic [N_PLAYERS-1:0] LocalBit = N_PLAYERS'(1);

  state_e               state_q;
  logic [31:0]          tick_cnt_q;
  logic [31:0]          to_cnt_q;
  logic                 tick_pend_q;
  logic                 over_q;
  logic [N_PLAYERS-1:0] rx_mask_q;

  logic        tick_hit;
  logic [3:0]  eat_cnt;
  logic [16:0] pts_sum;
  logic [15:0] pts_new;
  logic        speedup;
  logic [31:0] period_next;
  logic        stage_active;

  always_comb begin
    eat_cnt = '0;
    for (int i = 0; i < int'(N_PLAYERS); i++) begin
      eat_cnt = eat_cnt + 4'(eaten[i]);
    end
    tick_hit     = tick_cnt_q >= (tick_period - 32'd1);
    pts_sum      = {1'b0, points} + 17'(eat_cnt);
    pts_new      = pts_sum[16] ? 16'hffff : pts_sum[15:0];
    speedup      = (pts_new / 16'(SPEEDUP_EVERY)) > (points / 16'(SPEEDUP_EVERY));
    period_next  = (tick_period >= (MIN_TICK_CYCLES + SPEEDUP_STEP)) ?
                   (tick_period - SPEEDUP_STEP) : MIN_TICK_CYCLES;
    stage_active = (state_q == StSend) || (state_q == StWaitRx) || (state_q == StMove) ||
                   (state_q == StCollide) || (state_q == StUpdate);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      to_cnt_q    <= '0;
      tick_pend_q <= 1'b0;
      over_q      <= 1'b0;
      rx_mask_q   <= '0;
      send        <= 1'b0;
      move_start  <= 1'b0;
      coll_start  <= 1'b0;
      step_done   <= 1'b0;
      com_err     <= 1'b0;
      tick_period <= TICK_CYCLES;
      step_cnt    <= '0;
      points      <= '0;
    end else begin
      send       <= 1'b0;
      move_start <= 1'b0;
      coll_start <= 1'b0;
      step_done  <= 1'b0;

      // The tick keeps running while stages execute; an overrun is remembered as pending.
      if (state_q == StWaitTick) begin
        tick_cnt_q <= tick_cnt_q + 32'd1;
      end else if (stage_active) begin
        if (tick_hit) begin
          tick_pend_q <= 1'b1;
          tick_cnt_q  <= '0;
        end else begin
          tick_cnt_q <= tick_cnt_q + 32'd1;
        end
      end

      if (!run) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            step_cnt    <= '0;
            points      <= '0;
            com_err     <= 1'b0;
            tick_period <= TICK_CYCLES;
            tick_cnt_q  <= '0;
            tick_pend_q <= 1'b0;
            state_q     <= StWaitTick;
          end
          StWaitTick: begin
            if (tick_hit) begin
              tick_cnt_q <= '0;
              to_cnt_q   <= '0;
              send       <= 1'b1;
              state_q    <= StSend;
            end
          end
          StSend: begin
            rx_mask_q <= rcv_valid | LocalBit;
            to_cnt_q  <= to_cnt_q + 32'd1;
            if (N_PLAYERS == 1) begin
              move_start <= 1'b1;
              state_q    <= StMove;
            end else begin
              state_q <= StWaitRx;
            end
          end
          StWaitRx: begin
            rx_mask_q <= rx_mask_q | rcv_valid;
            to_cnt_q  <= to_cnt_q + 32'd1;
            if (&(rx_mask_q | rcv_valid)) begin
              move_start <= 1'b1;
              state_q    <= StMove;
            end else if (to_cnt_q == RX_TIMEOUT_CYCLES - 1) begin
              com_err <= 1'b1;
              state_q <= StError;
            end
          end
          StMove: begin
            if (move_done) begin
              coll_start <= 1'b1;
              state_q    <= StCollide;
            end
          end
          StCollide: begin
            // Counters commit on entry so they are already valid while step_done is high.
            if (coll_done) begin
              step_cnt  <= step_cnt + 16'd1;
              points    <= pts_new;
              over_q    <= game_over;
              step_done <= 1'b1;
              if (speedup) tick_period <= period_next;
              state_q   <= StUpdate;
            end
          end
          StUpdate: begin
            if (over_q) begin
              state_q <= StHalt;
            end else if (tick_pend_q || tick_hit) begin
              tick_pend_q <= 1'b0;
              tick_cnt_q  <= '0;
              to_cnt_q    <= '0;
              send        <= 1'b1;
              state_q     <= StSend;
            end else begin
              state_q <= StWaitTick;
            end
          end
          StHalt, StError: state_q <= state_q;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_step_seq.sv
// Randomized bench for game_step_seq: a step-level reference model feeds expectation
// queues that an independent monitor drains as the DUT emits its pulses.
module tb_game_step_seq;

  localparam int N     = 3;
  localparam int TICK  = 10;
  localparam int MINP  = 4;
  localparam int STEP  = 2;
  localparam int EVERY = 2;
  localparam int TO    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [N-1:0]  rcv_valid;
  logic          move_done;
  logic          coll_done;
  logic [N-1:0]  eaten;
  logic          game_over;
  logic          send, move_start, coll_start, step_done, com_err;
  logic [31:0]   tick_period;
  logic [15:0]   step_cnt, points;

  game_step_seq #(
    .N_PLAYERS(N), .TICK_CYCLES(TICK), .MIN_TICK_CYCLES(MINP), .SPEEDUP_STEP(STEP),
    .SPEEDUP_EVERY(EVERY), .RX_TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .rcv_valid(rcv_valid), .move_done(move_done),
    .coll_done(coll_done), .eaten(eaten), .game_over(game_over), .send(send),
    .move_start(move_start), .coll_start(coll_start), .step_done(step_done),
    .com_err(com_err), .tick_period(tick_period), .step_cnt(step_cnt), .points(points)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int sc;
    int pts;
    int per;
  } step_t;

  int    q_send[$];
  int    q_move[$];
  int    q_coll[$];
  int    q_done[$];
  int    q_err[$];
  step_t q_step[$];

  // Reference model state
  int m_steps, m_points, m_period;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  int anchor = 0, last_send = 0, last_move = 0, last_coll = 0;
  bit run_prev = 0, err_prev = 0;
  always @(negedge clk) begin
    if (rst) begin
      run_prev = 0;
      err_prev = 0;
    end else begin
      if (run && !run_prev) anchor = cyc + 1;
      chk("pulse_exclusive", int'(send) + int'(move_start) + int'(coll_start) + int'(step_done) <= 1, 1);
      if (send) begin
        chk("send_expected", q_send.size() > 0, 1);
        if (q_send.size() > 0) chk("send_interval", cyc - anchor, q_send.pop_front());
        anchor = cyc;
        last_send = cyc;
      end
      if (move_start) begin
        chk("move_expected", q_move.size() > 0, 1);
        if (q_move.size() > 0) chk("move_start_ofs", cyc - last_send, q_move.pop_front());
        last_move = cyc;
      end
      if (coll_start) begin
        chk("coll_expected", q_coll.size() > 0, 1);
        if (q_coll.size() > 0) chk("coll_start_ofs", cyc - last_move, q_coll.pop_front());
        last_coll = cyc;
      end
      if (step_done) begin
        chk("done_expected", (q_done.size() > 0) && (q_step.size() > 0), 1);
        if (q_done.size() > 0) chk("step_done_ofs", cyc - last_coll, q_done.pop_front());
        if (q_step.size() > 0) begin
          step_t e;
          e = q_step.pop_front();
          chk("step_cnt", step_cnt, e.sc);
          chk("points", points, e.pts);
          chk("tick_period", tick_period, e.per);
        end
      end
      if (com_err && !err_prev) begin
        chk("err_expected", q_err.size() > 0, 1);
        if (q_err.size() > 0) chk("com_err_ofs", cyc - last_send, q_err.pop_front());
      end
      run_prev = run;
      err_prev = com_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rcv_valid = '0;
    move_done = 1'b0;
    coll_done = 1'b0;
    eaten     = '0;
    game_over = 1'b0;
  endtask

  task automatic start_run();
    m_steps  = 0;
    m_points = 0;
    m_period = TICK;
    q_send.push_back(TICK);
    run = 1'b1;
  endtask

  task automatic stop_run();
    run = 1'b0;
    repeat (3) tick();
    chk("events_drained", q_move.size() + q_coll.size() + q_done.size() + q_step.size() +
        q_err.size(), 0);
    q_send.delete();
  endtask

  task automatic wait_send(output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (send) ok = 1;
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pulses"}, {send, move_start, coll_start, step_done}, 0);
    chk({tag, "_com_err"}, com_err, 0);
    chk({tag, "_period"}, tick_period, TICK);
    chk({tag, "_step_cnt"}, step_cnt, 0);
    chk({tag, "_points"}, points, 0);
  endtask

  // One full step: remote bits arrive at offsets rx1/rx2 after send; stages answer after dm/dc.
  task automatic do_step(input int rx1, input int rx2, input bit dup, input int dm, input int dc,
                         input logic [N-1:0] eat, input bit go);
    int r, mofs, u, old, t, tm, tc;
    bit ok, done;
    r    = (rx1 > rx2) ? rx1 : rx2;
    mofs = ((r < 1) ? 1 : r) + 1;
    u    = mofs + dm + dc + 2;
    old  = m_points;
    m_points = old + $countones(eat);
    if (m_points > 65535) m_points = 65535;
    if (m_points / EVERY > old / EVERY) m_period = (m_period - STEP < MINP) ? MINP : m_period - STEP;
    m_steps = (m_steps + 1) % 65536;
    q_move.push_back(mofs);
    q_coll.push_back(dm + 1);
    q_done.push_back(dc + 1);
    q_step.push_back('{sc: m_steps, pts: m_points, per: m_period});
    if (!go) q_send.push_back((u + 1 > m_period) ? u + 1 : m_period);
    wait_send(ok);
    t = 0; tm = -1; tc = -1; done = 0;
    while (ok && !done && t < 40) begin
      if (move_start) tm = t;
      if (coll_start) tc = t;
      if (step_done) done = 1;
      rcv_valid = {t == rx2, (t == rx1) || (dup && t == rx1 + 1), 1'($urandom)};
      move_done = (tm >= 0) && (t == tm + dm);
      coll_done = (tc >= 0) && (t == tc + dc);
      eaten     = coll_done ? eat : N'($urandom);
      game_over = coll_done ? go : 1'($urandom);
      if (!done) begin
        tick();
        t++;
      end
    end
    if (ok && !done) chk("step_complete", 0, 1);
    clear_inputs();
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    run = 1'b0;
    clear_inputs();
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) tick();

    // Basic, split reception, completion on the timeout boundary, speed-ups to the floor
    start_run();
    do_step(2, 2, 0, 1, 1, 3'b000, 0);
    do_step(1, 5, 1, 0, 0, 3'b000, 0);
    do_step(7, 3, 0, 0, 0, 3'b000, 0);
    for (int i = 0; i < 4; i++) do_step(0, 1, 0, 0, 0, 3'b011, 0);
    for (int i = 0; i < 10; i++)
      do_step($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 2),
              $urandom_range(0, 2), N'($urandom), 0);
    do_step(1, 2, 0, 1, 0, 3'b100, 1);
    repeat (30) tick();
    stop_run();

    // Link timeout, then cleared by a fresh run
    start_run();
    do_step(3, 1, 0, 0, 1, 3'b111, 0);
    q_err.push_back(TO);
    wait_send(ok);
    for (int t = 0; t < 15; t++) begin
      rcv_valid = {1'b0, (t == 1) || (t == 3), 1'b0};
      tick();
    end
    clear_inputs();
    chk("com_err_sticky", com_err, 1);
    stop_run();
    start_run();
    repeat (2) tick();
    chk("com_err_cleared", com_err, 0);
    chk("step_cnt_cleared", step_cnt, 0);
    chk("points_cleared", points, 0);

    // Drop run in the first MOVE cycle: no collision stage may follow
    q_move.push_back(2);
    wait_send(ok);
    rcv_valid = 3'b110;
    tick();
    rcv_valid = '0;
    for (int i = 0; i < 10 && !move_start; i++) tick();
    chk("abort_in_move", move_start, 1);
    run = 1'b0;
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    repeat (5) tick();
    stop_run();

    // Asynchronous reset while waiting for remote directions
    start_run();
    do_step(1, 1, 0, 0, 0, 3'b011, 0);
    chk("pre_reset_points", points, 2);
    wait_send(ok);
    tick();
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    run = 1'b0;
    q_send.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    chk("queues_empty", q_send.size() + q_move.size() + q_coll.size() + q_done.size() +
        q_step.size() + q_err.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_step_seq.md
Name: game_step_seq

Overview:
- Parametrised per-tick game step sequencer for N_PLAYERS snakes.
- Replaces the free-running divided-clock strobe that currently paces the move/collision/point datapath.
- Each game tick it strobes the link to send the local direction, then waits for every remote player's direction, with a timeout.
- It then starts move and collision in order, counts steps and points, and shortens the tick period as points accumulate.

Parameters:
- N_PLAYERS, 2, number of snakes; player 0 is local, 1..N-1 are remote. Legal range 1..8.
- TICK_CYCLES, 7_500_000, initial tick period in clk cycles (10 Hz at 75 MHz).
- MIN_TICK_CYCLES, 1_875_000, floor for the tick period.
- SPEEDUP_STEP, 375_000, cycles removed from the period per speed-up.
- SPEEDUP_EVERY, 4, total points eaten between speed-ups.
- RX_TIMEOUT_CYCLES, 750_000, maximum wait for remote directions.

Ports:
- clk  in  1  system clock (75 MHz)
- rst  in  1  asynchronous, active-high reset
- run  in  1  high while mode is GAME
- rcv_valid  in  N_PLAYERS  one pulse per remote direction received; bit 0 is ignored
- move_done  in  1  pulse: move stage finished
- coll_done  in  1  pulse: collision stage finished
- eaten  in  N_PLAYERS  per-player eat flags, valid with coll_done
- game_over  in  1  won/lost/draw, valid with coll_done
- send  out  1  1-cycle pulse: transmit local direction
- move_start  out  1  1-cycle pulse
- coll_start  out  1  1-cycle pulse
- step_done  out  1  1-cycle pulse at end of step
- com_err  out  1  sticky link-timeout flag
- tick_period  out  32  current period in cycles
- step_cnt  out  16  completed steps, wraps at 65535->0
- points  out  16  total points eaten, saturates at 65535

Behaviour:
- Reset values: all pulses 0, com_err 0, tick_period = TICK_CYCLES, step_cnt 0, points 0, state IDLE.
- FSM states: IDLE, WAIT_TICK, SEND, WAIT_RX, MOVE, COLLIDE, UPDATE, HALT, ERROR.
- IDLE: on run=1, clear step_cnt, points and com_err, load tick_period = TICK_CYCLES, clear the tick counter, go to WAIT_TICK.
- WAIT_TICK: the tick counter increments each cycle. When it equals tick_period-1, clear it and go to SEND. The first send therefore occurs tick_period cycles after leaving IDLE.
- SEND:
  - Assert send for exactly this cycle.
  - Clear the rx mask, then OR in rcv_valid[N-1:1] from this same cycle.
  - Clear the timeout counter.
  - Go to WAIT_RX, or go straight to MOVE if N_PLAYERS=1.
- WAIT_RX:
  - Mask |= rcv_valid each cycle. Duplicate pulses are harmless.
  - When all remote bits are set (including bits set this cycle), go to MOVE.
  - Otherwise, when the timeout counter reaches RX_TIMEOUT_CYCLES-1, set com_err=1 and go to ERROR. Completion wins over timeout in the same cycle.
- MOVE: pulse move_start in the first cycle of the state. Wait for move_done; a move_done in that same first cycle is accepted. Then go to COLLIDE.
- COLLIDE: pulse coll_start in the first cycle. On coll_done, latch eaten and game_over, then go to UPDATE.
- UPDATE (1 cycle):
  - step_cnt++.
  - points += popcount(eaten), saturating.
  - If floor(points_new/SPEEDUP_EVERY) > floor(points_old/SPEEDUP_EVERY): tick_period = max(tick_period - SPEEDUP_STEP, MIN_TICK_CYCLES). At most one step per UPDATE, even when several multiples are crossed.
  - Pulse step_done.
  - Go to HALT if game_over latched, else to WAIT_TICK. The tick counter keeps running during stages, so the step rate is independent of stage latency as long as the stages finish within a period.
- Stage overrun: if the tick counter reaches tick_period-1 outside WAIT_TICK, the tick is held pending. SEND follows UPDATE directly and the counter restarts from 0. Only one tick can be pending.
- HALT and ERROR: no pulses are issued; counters and com_err hold. Leave only on run=0, going to IDLE.
- run=0 in any state: next state is IDLE, no pulses in that cycle. com_err, step_cnt, points and tick_period hold until the next run rise.
- Pulses never overlap: at most one of send, move_start, coll_start, step_done is high per cycle.
- Asynchronous reset mid-step aborts immediately to the reset values.

Test Plan (N_PLAYERS=3, TICK=10, MIN=4, STEP=2, EVERY=2, TIMEOUT=8):
- Basic step: raise run; rcv_valid=3'b110 two cycles after send; move_done and coll_done 1 cycle after their starts. -> send 10 cycles after run; move_start follows, then coll_start, then step_done; step_cnt=1; next send exactly 10 cycles after the previous one.
- Split reception: rcv_valid bit1 at +1 cycle and bit2 at +5 cycles, plus a duplicate of bit1. -> move_start only after bit2 arrives; no com_err.
- Timeout: only bit1 arrives. -> com_err=1 8 cycles after send; no move_start; run=0 then 1 -> com_err cleared.
- Speed-up: eaten=3'b011 on step 1. -> points=2, tick_period 10->8. Three more such steps -> period 6, then 4, then stays 4.
- Game over: game_over=1 with coll_done. -> step_done pulses, then no further send while run stays 1.
- Abort: drop run during MOVE. -> IDLE next cycle, no coll_start. Assert rst during WAIT_RX -> all outputs return to reset values asynchronously.
